// File: rtl/letter_segmenter.sv
// Groups classifier frames into runs by their top-2 characters, averages each run's top-3
// logits with a serial divider and hands qualifying runs to the Viterbi decoder as letters.
module letter_segmenter #(
  parameter int unsigned MIN_RUN  = 6,
  parameter int unsigned WORD_GAP = 31,
  parameter int unsigned CNT_W    = 7,
  parameter int unsigned BLANK    = 26
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_valid,
  output logic        o_frame_ready,
  input  logic [14:0] i_chars,
  input  logic [95:0] i_logits,
  output logic        o_viter_start,
  output logic        o_viter_next,
  output logic [14:0] o_char,
  output logic [95:0] o_prob,
  input  logic        i_viter_stepped,
  output logic        o_word_end,
  output logic        o_busy
);

  localparam int unsigned AccW    = 32 + CNT_W;
  localparam int unsigned DivCntW = $clog2(AccW);

  localparam logic [DivCntW-1:0] DivLast = DivCntW'(AccW - 1);
  localparam logic [CNT_W-1:0]   LenMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   LenOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   MinRun  = CNT_W'(MIN_RUN);
  localparam logic [CNT_W-1:0]   WordGap = CNT_W'(WORD_GAP);
  localparam logic [4:0]         Blank   = 5'(BLANK);

  typedef enum logic [1:0] {StIdle, StDiv, StIssue, StWait} state_e;

  state_e state_q, state_d;

  logic [2:0][4:0]      run_char_q, run_char_d;
  logic [2:0][AccW-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     run_len_q, run_len_d;
  logic                 word_open_q, word_open_d;
  logic                 gap_flag_q, gap_flag_d;
  logic                 word_end_q, word_end_d;
  logic [2:0][4:0]      pend_char_q, pend_char_d;
  logic [2:0][31:0]     pend_logit_q, pend_logit_d;
  logic [2:0][4:0]      char_out_q, char_out_d;
  logic [2:0][AccW-1:0] quo_q, quo_d;
  logic [2:0][CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]     div_len_q, div_len_d;
  logic [DivCntW-1:0]   div_cnt_q, div_cnt_d;

  logic [2:0][4:0]  in_char;
  logic [2:0][31:0] in_logit;
  logic             accept, run_empty, is_match, qualifies, issue_run;

  assign in_char  = i_chars;
  assign in_logit = i_logits;

  always_comb begin
    accept    = i_frame_valid && (state_q == StIdle);
    run_empty = (run_len_q == '0);
    is_match  = !run_empty && (in_char[0] == run_char_q[0]) && (in_char[1] == run_char_q[1]);
    qualifies = (run_len_q >= MinRun) && (run_char_q[0] != Blank) && (run_char_q[1] != Blank);
    issue_run = accept && !run_empty && !is_match && qualifies;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      run_char_q   <= '0;
      acc_q        <= '0;
      run_len_q    <= '0;
      word_open_q  <= 1'b0;
      gap_flag_q   <= 1'b0;
      word_end_q   <= 1'b0;
      pend_char_q  <= '0;
      pend_logit_q <= '0;
      char_out_q   <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      div_len_q    <= '0;
      div_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      run_char_q   <= run_char_d;
      acc_q        <= acc_d;
      run_len_q    <= run_len_d;
      word_open_q  <= word_open_d;
      gap_flag_q   <= gap_flag_d;
      word_end_q   <= word_end_d;
      pend_char_q  <= pend_char_d;
      pend_logit_q <= pend_logit_d;
      char_out_q   <= char_out_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      div_len_q    <= div_len_d;
      div_cnt_q    <= div_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (issue_run) state_d = StDiv;
      StDiv:   if (div_cnt_q == DivLast) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (i_viter_stepped) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    logic [CNT_W:0]   trial;
    logic             do_open;
    logic [2:0][4:0]  src_char;
    logic [2:0][31:0] src_logit;

    run_char_d   = run_char_q;
    acc_d        = acc_q;
    run_len_d    = run_len_q;
    word_open_d  = word_open_q;
    gap_flag_d   = gap_flag_q;
    word_end_d   = 1'b0;
    pend_char_d  = pend_char_q;
    pend_logit_d = pend_logit_q;
    char_out_d   = char_out_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    div_len_d    = div_len_q;
    div_cnt_d    = div_cnt_q;
    trial        = '0;
    do_open      = 1'b0;
    // A new run opens either from the live frame or from the frame parked during issue.
    src_char     = (state_q == StWait) ? pend_char_q : in_char;
    src_logit    = (state_q == StWait) ? pend_logit_q : in_logit;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_match) begin
            if (run_len_q != LenMax) begin
              run_len_d = run_len_q + LenOne;
              for (int k = 0; k < 3; k++) begin
                if (in_char[k] == run_char_q[k]) acc_d[k] = acc_q[k] + AccW'(in_logit[k]);
              end
            end
            if ((run_char_q[0] == Blank) && (run_len_d == WordGap) && !gap_flag_q) begin
              word_end_d  = 1'b1;
              gap_flag_d  = 1'b1;
              word_open_d = 1'b0;
            end
          end else if (issue_run) begin
            char_out_d   = run_char_q;
            quo_d        = acc_q;
            rem_d        = '0;
            div_len_d    = run_len_q;
            div_cnt_d    = '0;
            pend_char_d  = in_char;
            pend_logit_d = in_logit;
          end else begin
            do_open = 1'b1;
          end
        end
      end
      StDiv: begin
        div_cnt_d = div_cnt_q + DivCntW'(1);
        // One restoring step per slot: the quotient shifts in where the dividend shifts out.
        for (int k = 0; k < 3; k++) begin
          trial = {rem_q[k], quo_q[k][AccW-1]};
          if (trial >= {1'b0, div_len_q}) begin
            trial    = trial - {1'b0, div_len_q};
            quo_d[k] = {quo_q[k][AccW-2:0], 1'b1};
          end else begin
            quo_d[k] = {quo_q[k][AccW-2:0], 1'b0};
          end
          rem_d[k] = trial[CNT_W-1:0];
        end
      end
      StIssue: word_open_d = 1'b1;
      StWait:  if (i_viter_stepped) do_open = 1'b1;
      default: ;
    endcase

    if (do_open) begin
      run_char_d = src_char;
      for (int k = 0; k < 3; k++) acc_d[k] = AccW'(src_logit[k]);
      run_len_d  = LenOne;
      gap_flag_d = 1'b0;
    end
  end

  always_comb begin
    o_frame_ready = (state_q == StIdle);
    o_busy        = (state_q != StIdle);
    o_viter_start = (state_q == StIssue) && !word_open_q;
    o_viter_next  = (state_q == StIssue) && word_open_q;
    o_word_end    = word_end_q;
    o_char        = char_out_q;
    o_prob        = {quo_q[2][31:0], quo_q[1][31:0], quo_q[0][31:0]};
  end

endmodule
